// File: rtl/dft_seq_pkg.sv
// -----------------------------------------------------------------------------
// dft_seq_pkg
// Shared definitions for the scan test sequencer:
//   - default chain / primary-input / primary-output / pattern-counter sizes
//   - the sequencer state enumeration
//   - cnt_width(): number of bits needed to count 0..n-1 (minimum 1)
// -----------------------------------------------------------------------------
package dft_seq_pkg;

    localparam int DEF_CHAIN_LEN = 14;
    localparam int DEF_PI_W      = 3;
    localparam int DEF_PO_W      = 6;
    localparam int DEF_CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_FLUSH   = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_e;

    // Ceiling log2 with a floor of one bit, usable in parameter context.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scan_test_sequencer_if.sv
// -----------------------------------------------------------------------------
// scan_test_sequencer_if
// Pattern input stream and response output stream of the scan sequencer.
//   Pattern stream : PAT_VALID/PAT_READY handshake, PAT_STATE (chain load,
//                    bit i -> cell i), PAT_PI (capture-time inputs), PAT_LAST.
//   Response stream: RSP_VALID/RSP_READY handshake, RSP_STATE (unloaded chain,
//                    cell i in bit i), RSP_PO (outputs sampled at capture).
// modport master : pattern source / response consumer (tester side)
// modport slave  : the sequencer
// -----------------------------------------------------------------------------
interface scan_test_sequencer_if #(
    parameter int CHAIN_LEN = dft_seq_pkg::DEF_CHAIN_LEN,
    parameter int PI_W      = dft_seq_pkg::DEF_PI_W,
    parameter int PO_W      = dft_seq_pkg::DEF_PO_W
);
    logic                 PAT_VALID;
    logic                 PAT_READY;
    logic [CHAIN_LEN-1:0] PAT_STATE;
    logic [PI_W-1:0]      PAT_PI;
    logic                 PAT_LAST;

    logic                 RSP_VALID;
    logic                 RSP_READY;
    logic [CHAIN_LEN-1:0] RSP_STATE;
    logic [PO_W-1:0]      RSP_PO;

    modport master (
        output PAT_VALID, PAT_STATE, PAT_PI, PAT_LAST, RSP_READY,
        input  PAT_READY, RSP_VALID, RSP_STATE, RSP_PO
    );

    modport slave (
        input  PAT_VALID, PAT_STATE, PAT_PI, PAT_LAST, RSP_READY,
        output PAT_READY, RSP_VALID, RSP_STATE, RSP_PO
    );
endinterface

// File: rtl/scan_shift_unit.sv
// -----------------------------------------------------------------------------
// scan_shift_unit
// Datapath for one chain pass: pattern shift-out register, SO collect
// register and the shift-cycle counter.
//   clk, rst        : clock, synchronous active-high reset
//   clear_i         : zero all state (session start)
//   load_i          : load pat_i and restart the counter
//   shift_i         : advance one scan cycle
//   pat_i           : chain load value, bit 0 is shifted out first
//   so_i            : scan-out bit from chain cell 0
//   si_o            : bit to present on scan-in this cycle
//   last_bit_o      : current shift cycle is the final one of the pass
//   collect_next_o  : collect register including this cycle's SO bit
// -----------------------------------------------------------------------------
module scan_shift_unit
    import dft_seq_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [CHAIN_LEN-1:0] pat_i,
    input  logic                 so_i,
    output logic                 si_o,
    output logic                 last_bit_o,
    output logic [CHAIN_LEN-1:0] collect_next_o
);
    localparam int SC_W = cnt_width(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] col_q, col_d;
    logic [SC_W-1:0]      cnt_q, cnt_d;

    // SO enters at the top so the first bit unloaded (cell 0) ends in bit 0.
    assign collect_next_o = {so_i, col_q[CHAIN_LEN-1:1]};
    assign si_o           = pat_q[0];
    assign last_bit_o     = (cnt_q == SC_W'(CHAIN_LEN - 1));

    // Next-state for pattern, collect and counter registers.
    always_comb begin
        pat_d = pat_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            pat_d = {CHAIN_LEN{1'b0}};
            col_d = {CHAIN_LEN{1'b0}};
            cnt_d = {SC_W{1'b0}};
        end else if (load_i) begin
            pat_d = pat_i;
            cnt_d = {SC_W{1'b0}};
        end else if (shift_i) begin
            pat_d = {1'b0, pat_q[CHAIN_LEN-1:1]};
            col_d = collect_next_o;
            // Counter wraps to zero as the pass ends.
            if (last_bit_o) begin
                cnt_d = {SC_W{1'b0}};
            end else begin
                cnt_d = cnt_q + SC_W'(1);
            end
        end else begin
            pat_d = pat_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= {CHAIN_LEN{1'b0}};
            col_q <= {CHAIN_LEN{1'b0}};
            cnt_q <= {SC_W{1'b0}};
        end else begin
            pat_q <= pat_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_test_sequencer.sv
// -----------------------------------------------------------------------------
// scan_test_sequencer
// Runs full-scan sessions on a muxed-D scan chain: fetch a pattern, shift it
// in while the previous capture shifts out, capture, repeat; a final flush
// unloads the last capture. The sequencer owns the core clock enable, so the
// core is frozen whenever the sequencer waits for a pattern or a consumer.
//   CK, RST   : clock, synchronous active-high reset
//   START     : one-cycle pulse starting a session (only honoured in IDLE)
//   bus       : pattern and response valid/ready streams (slave side)
//   SE, SI    : scan enable / scan-in to the core;  SO : scan-out from cell 0
//   CUT_PI    : core primary inputs (latched pattern PI)
//   CUT_PO    : core primary outputs, sampled at capture
//   CUT_CKEN  : core clock enable
//   BUSY      : not IDLE;  DONE : one-cycle end-of-session pulse
//   PAT_CNT   : captures performed this session (saturating)
// -----------------------------------------------------------------------------
module scan_test_sequencer
    import dft_seq_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int PI_W      = DEF_PI_W,
    parameter int PO_W      = DEF_PO_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       CK,
    input  logic                       RST,
    input  logic                       START,
    scan_test_sequencer_if.slave       bus,
    output logic                       SE,
    output logic                       SI,
    input  logic                       SO,
    output logic [PI_W-1:0]            CUT_PI,
    input  logic [PO_W-1:0]            CUT_PO,
    output logic                       CUT_CKEN,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [CNT_W-1:0]           PAT_CNT
);
    seq_state_e           state_q, state_d;
    logic [PI_W-1:0]      pi_q, pi_d;
    logic                 last_q, last_d;
    logic                 pending_q, pending_d;   // a capture waits in the chain
    logic                 last_cap_q, last_cap_d; // final capture done, flush next
    logic [PO_W-1:0]      po_q, po_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [CHAIN_LEN-1:0] rsp_state_q, rsp_state_d;
    logic [PO_W-1:0]      rsp_po_q, rsp_po_d;
    logic [CNT_W-1:0]     pat_cnt_q, pat_cnt_d;

    logic                 load_s, shift_s, clear_s;
    logic                 si_s, last_bit_s;
    logic [CHAIN_LEN-1:0] collect_s;

    scan_shift_unit #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_shift (
        .clk            (CK),
        .rst            (RST),
        .clear_i        (clear_s),
        .load_i         (load_s),
        .shift_i        (shift_s),
        .pat_i          (bus.PAT_STATE),
        .so_i           (SO),
        .si_o           (si_s),
        .last_bit_o     (last_bit_s),
        .collect_next_o (collect_s)
    );

    assign SE            = (state_q == ST_SHIFT) || (state_q == ST_FLUSH);
    assign CUT_CKEN      = SE || (state_q == ST_CAPTURE);
    assign SI            = (state_q == ST_SHIFT) ? si_s : 1'b0;
    assign CUT_PI        = pi_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign DONE          = (state_q == ST_DONE);
    assign PAT_CNT       = pat_cnt_q;
    assign bus.PAT_READY = (state_q == ST_FETCH);
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_STATE = rsp_state_q;
    assign bus.RSP_PO    = rsp_po_q;

    // Next-state, datapath strobes and response register updates.
    always_comb begin
        state_d     = state_q;
        pi_d        = pi_q;
        last_d      = last_q;
        pending_d   = pending_q;
        last_cap_d  = last_cap_q;
        po_d        = po_q;
        rsp_state_d = rsp_state_q;
        rsp_po_d    = rsp_po_q;
        pat_cnt_d   = pat_cnt_q;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        clear_s     = 1'b0;

        // Consumer pop; a load below can only happen while empty.
        if (rsp_valid_q && bus.RSP_READY) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_FETCH;
                    pat_cnt_d  = {CNT_W{1'b0}};
                    pending_d  = 1'b0;
                    last_cap_d = 1'b0;
                    clear_s    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.PAT_VALID) begin
                    pi_d   = bus.PAT_PI;
                    last_d = bus.PAT_LAST;
                    load_s = 1'b1;
                    // Unloading into a full holding register would lose data.
                    state_d = rsp_valid_q ? ST_HOLD : ST_SHIFT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (!rsp_valid_q) begin
                    state_d = last_cap_q ? ST_FLUSH : ST_SHIFT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (last_bit_s) begin
                    state_d   = ST_CAPTURE;
                    pending_d = 1'b0;
                    if (pending_q) begin
                        rsp_state_d = collect_s;
                        rsp_po_d    = po_q;
                        rsp_valid_d = 1'b1;
                    end else begin
                        rsp_valid_d = rsp_valid_q;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                po_d      = CUT_PO;
                pending_d = 1'b1;
                if (pat_cnt_q == {CNT_W{1'b1}}) begin
                    pat_cnt_d = pat_cnt_q;
                end else begin
                    pat_cnt_d = pat_cnt_q + CNT_W'(1);
                end
                if (last_q) begin
                    last_cap_d = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                shift_s = 1'b1;
                if (last_bit_s) begin
                    rsp_state_d = collect_s;
                    rsp_po_d    = po_q;
                    rsp_valid_d = 1'b1;
                    pending_d   = 1'b0;
                    last_cap_d  = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            pi_q        <= {PI_W{1'b0}};
            last_q      <= 1'b0;
            pending_q   <= 1'b0;
            last_cap_q  <= 1'b0;
            po_q        <= {PO_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_state_q <= {CHAIN_LEN{1'b0}};
            rsp_po_q    <= {PO_W{1'b0}};
            pat_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            pi_q        <= pi_d;
            last_q      <= last_d;
            pending_q   <= pending_d;
            last_cap_q  <= last_cap_d;
            po_q        <= po_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_state_q <= rsp_state_d;
            rsp_po_q    <= rsp_po_d;
            pat_cnt_q   <= pat_cnt_d;
        end
    end

endmodule

// File: doc/scan_test_sequencer.md
Name: scan_test_sequencer

Overview:
- Drives one full-scan pass over a muxed-D scan chain wrapped around a benchmark core: shift-in, capture, shift-out, repeat.
- Patterns arrive over a valid/ready stream. Unloaded responses leave over a second valid/ready stream.
- Owns the core's clock-enable, so every stall is state-preserving.
- Sits between the pattern source/response checker and the scan-inserted core netlist.

Parameters:
- CHAIN_LEN, 14: scan cells in the chain.
- PI_W, 3: core functional inputs.
- PO_W, 6: core functional outputs.
- CNT_W, 16: pattern-counter width.

Ports:
- CK  in  1  rising-edge clock for the sequencer and the core.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a test session.
- PAT_VALID  in  1  pattern available.
- PAT_READY  out  1  sequencer accepts a pattern.
- PAT_STATE  in  CHAIN_LEN  chain load value; bit i lands in chain cell i (cell 0 = SO end).
- PAT_PI  in  PI_W  primary-input value applied at capture.
- PAT_LAST  in  1  marks the final pattern of the session.
- SE  out  1  scan enable to the core.
- SI  out  1  scan-in bit.
- SO  in  1  scan-out bit from cell 0.
- CUT_PI  out  PI_W  core primary inputs.
- CUT_PO  in  PO_W  core primary outputs.
- CUT_CKEN  out  1  core clock enable; the core flops update only when it is 1.
- RSP_VALID  out  1  response word available.
- RSP_READY  in  1  consumer accepts the response.
- RSP_STATE  out  CHAIN_LEN  unloaded chain contents, cell i in bit i.
- RSP_PO  out  PO_W  CUT_PO sampled at the matching capture.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  one-cycle pulse at session end.
- PAT_CNT  out  CNT_W  number of captures this session.

Behaviour:
- Clock and reset: one clock, CK. RST is synchronous and active-high.
- Reset state: state IDLE. All outputs 0: SE, SI, CUT_PI, CUT_CKEN, PAT_READY, RSP_VALID, RSP_STATE, RSP_PO, BUSY, DONE, PAT_CNT. Internal pending flag and shift counter cleared.
- RST mid-session: abandons the session with no DONE and no partial response. RST wins over START in the same cycle.
- States: IDLE, FETCH, HOLD, SHIFT, CAPTURE, FLUSH, DONE.
- IDLE:
  - START moves to FETCH and clears PAT_CNT.
  - START in any other state is ignored.
- FETCH:
  - PAT_READY=1, CUT_CKEN=0.
  - On PAT_VALID&PAT_READY: latch PAT_STATE, PAT_PI and PAT_LAST. CUT_PI takes the latched PI from the next cycle.
  - Next state is SHIFT if RSP_VALID=0, otherwise HOLD.
- HOLD:
  - CUT_CKEN=0, SE=0.
  - Waits for RSP_VALID=0, then goes to SHIFT, or to FLUSH if the last capture is done.
- SHIFT (exactly CHAIN_LEN cycles):
  - SE=1, CUT_CKEN=1.
  - SI = latched bit k on shift cycle k, for k = 0..CHAIN_LEN-1.
  - SO sampled each cycle into collect bit k.
- End of SHIFT:
  - If the pending flag is set, load RSP_STATE with the collected bits, load RSP_PO with the captured PO, and set RSP_VALID on the next edge.
  - The first pattern of a session produces no response.
- CAPTURE (1 cycle):
  - SE=0, CUT_CKEN=1.
  - Sample CUT_PO, set the pending flag, increment PAT_CNT (saturating).
  - If the latched last flag is 0 go to FETCH, otherwise go to HOLD, then FLUSH.
- FLUSH:
  - Same as SHIFT but SI=0.
  - At its end, load the response holding register as above and go to DONE.
- DONE: DONE=1 for one cycle, then IDLE.
- RSP_VALID: cleared when RSP_VALID&RSP_READY.
- Holding register: single entry. Shift never begins while it is full, so no response is ever lost or overwritten.
- CUT_CKEN=0 in IDLE, FETCH, HOLD and DONE. The core state is frozen across any stall of any length.
- Latency: pattern accepted at edge t with the holding register empty:
  - shift cycles t+1 .. t+CHAIN_LEN;
  - capture at t+CHAIN_LEN+1;
  - 16 cycles per pattern with default CHAIN_LEN.
- Shift counter width: clog2(CHAIN_LEN). Wraps to 0 on leaving SHIFT/FLUSH.

Decomposition:
- Package dft_seq_pkg holds:
  - the state enumeration;
  - default CHAIN_LEN/PI_W/PO_W constants;
  - the counter-width function.
- One sub-module, scan_shift_unit:
  - pattern shift-out register, SO collect register, and shift counter;
  - controlled by load/shift/clear strobes and signalling last-bit.
- The FSM and response holding register stay in the top module.

Test Plan (bench chain model: capture loads ~state, PO=6'h2A):
- Single pattern: PAT_STATE=14'h2AAA, PAT_PI=3'b101, PAT_LAST=1, RSP_READY=1
  -> SE high 14 cycles, then capture with CUT_PI=3'b101, then flush;
  -> exactly one response, RSP_STATE=14'h1555, RSP_PO=6'h2A;
  -> DONE pulse; PAT_CNT=1.
- Three patterns 14'h0001, 14'h3FFF, 14'h1234 back-to-back, PAT_VALID and RSP_READY held 1
  -> responses 14'h3FFE, 14'h0000, 14'h2DCB in order;
  -> DONE 3*16+14+1 cycles after first acceptance.
- RSP_READY=0 for 40 cycles after the first response
  -> sequencer parks in HOLD with CUT_CKEN=0, SE=0;
  -> model state unchanged;
  -> on release, remaining responses are bit-exact.
- PAT_VALID gap of 10 cycles between patterns
  -> stays in FETCH with CUT_CKEN=0;
  -> PAT_CNT unchanged until the next capture.
- RST asserted on shift cycle 7
  -> next cycle all outputs 0, BUSY=0;
  -> fresh START runs a full single-pattern session correctly.
- START pulsed while BUSY, and START coincident with RST
  -> both ignored; no extra session, no DONE.
